// File: rtl/wb_bram_checker.sv
// Wishbone B4 pipelined BRAM self-test master: writes a seeded pattern, reads it back,
// and reports pass/fault plus a saturating mismatch count.
module wb_bram_checker #(
    parameter int            AW      = 8,
    parameter int            DW      = 8,
    parameter int            DEPTH   = 256,
    parameter logic [DW-1:0] SEED    = 'hA5,
    parameter int            TIMEOUT = 255
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_start,
    output logic                               o_wb_cyc,
    output logic                               o_wb_stb,
    output logic                               o_wb_we,
    output logic [AW-1:0]                      o_wb_addr,
    output logic [DW-1:0]                      o_wb_data,
    output logic [((DW/8 > 0) ? DW/8 : 1)-1:0] o_wb_sel,
    input  logic                               i_wb_stall,
    input  logic                               i_wb_ack,
    input  logic                               i_wb_err,
    input  logic [DW-1:0]                      i_wb_data,
    output logic                               o_busy,
    output logic                               o_done,
    output logic                               o_pass,
    output logic                               o_fault,
    output logic [AW:0]                        o_err_count
);
    localparam int              PW       = AW + DW;
    localparam int              TW       = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0]   LAST     = AW'(DEPTH - 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW:0]     CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_WAIT, WR_GAP, RD_REQ, RD_WAIT, RD_GAP, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          cyc_q, cyc_d, stb_q, stb_d;
    logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d, fault_q, fault_d;
    logic [AW:0]   err_cnt_q, err_cnt_d;

    logic [PW-1:0] addr_ext;
    logic [DW-1:0] pattern;
    logic          in_wr, in_xfer, waiting, ack_ok, tmo_hit, abort;

    assign addr_ext = PW'(addr_q);
    assign pattern  = addr_ext[DW-1:0] ^ SEED;
    assign in_wr    = (state_q == WR_REQ) || (state_q == WR_WAIT);
    assign waiting  = (state_q == WR_WAIT) || (state_q == RD_WAIT);
    assign in_xfer  = in_wr || (state_q == RD_REQ) || (state_q == RD_WAIT);
    assign ack_ok   = waiting && i_wb_ack;
    // TIMEOUT cycles spent in REQ/WAIT without an ack ends the run.
    assign tmo_hit  = (tmo_q == TMO_LAST);
    assign abort    = in_xfer && (i_wb_err || (tmo_hit && !ack_ok));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        tmo_d     = tmo_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        fault_d   = fault_q;
        err_cnt_d = err_cnt_q;
        if (in_xfer) tmo_d = tmo_q + 1'b1;

        case (state_q)
            IDLE: if (i_start) begin
                done_d    = 1'b0;
                pass_d    = 1'b0;
                fault_d   = 1'b0;
                err_cnt_d = '0;
                addr_d    = '0;
                busy_d    = 1'b1;
                state_d   = WR_REQ;
                cyc_d     = 1'b1;
                stb_d     = 1'b1;
                tmo_d     = '0;
            end
            WR_REQ, RD_REQ: if (!i_wb_stall) begin
                stb_d   = 1'b0;
                state_d = (state_q == WR_REQ) ? WR_WAIT : RD_WAIT;
            end
            WR_WAIT: if (i_wb_ack) begin
                cyc_d = 1'b0;
                if (addr_q == LAST) begin
                    addr_d  = '0;
                    state_d = RD_GAP;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = WR_GAP;
                end
            end
            RD_WAIT: if (i_wb_ack) begin
                cyc_d = 1'b0;
                if (i_wb_data != pattern && err_cnt_q != CNT_MAX)
                    err_cnt_d = err_cnt_q + 1'b1;
                if (addr_q == LAST) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = RD_GAP;
                end
            end
            WR_GAP, RD_GAP: begin
                state_d = (state_q == WR_GAP) ? WR_REQ : RD_REQ;
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                tmo_d   = '0;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = DONE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            fault_d = 1'b1;
        end
        // Status is latched on the way into DONE so it is valid during the DONE cycle.
        if (state_d == DONE) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = !fault_d && (err_cnt_d == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            tmo_q     <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fault_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tmo_q     <= tmo_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fault_q   <= fault_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = stb_q;
    assign o_wb_we     = in_wr;
    assign o_wb_addr   = addr_q;
    assign o_wb_data   = in_wr ? pattern : '0;
    assign o_wb_sel    = '1;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_pass      = pass_q;
    assign o_fault     = fault_q;
    assign o_err_count = err_cnt_q;
endmodule

// File: tb/tb_wb_bram_checker.sv
// Directed bench for wb_bram_checker: a negedge-driven Wishbone slave model with
// stall/corrupt/error knobs, and one task per scenario.
module tb_wb_bram_checker;
    localparam int AW = 8, DW = 8, DEPTH = 4, TIMEOUT = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, start = 1'b0;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_wdata;
    logic [0:0]    wb_sel;
    logic          wb_stall = 1'b0, wb_ack = 1'b0, wb_err = 1'b0;
    logic [DW-1:0] wb_rdata = '0;
    logic          busy, done, pass, fault;
    logic [AW:0]   err_count;

    wb_bram_checker #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .SEED(8'hA5), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
        .o_wb_data(wb_wdata), .o_wb_sel(wb_sel), .i_wb_stall(wb_stall), .i_wb_ack(wb_ack),
        .i_wb_err(wb_err), .i_wb_data(wb_rdata), .o_busy(busy), .o_done(done),
        .o_pass(pass), .o_fault(fault), .o_err_count(err_count)
    );

    int vectors = 0, miscompares = 0;

    // Slave model knobs and bookkeeping
    logic [DW-1:0] mem [0:255];
    int   stall_cnt = 0, corrupt_addr = -1, err_rd_addr = -1, wr_acc = 0, rd_acc = 0;
    logic spur_ack = 1'b0, pend_ack = 1'b0, pend_err = 1'b0;
    logic [DW-1:0] pend_data = '0;
    logic [7:0] exp_pat [4] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};

    // Responds within the cycle it observes; ack/err follow one cycle after accept.
    always @(negedge clk) begin
        if (rst) begin
            wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0; wb_rdata = '0;
            pend_ack = 1'b0; pend_err = 1'b0;
        end else begin
            wb_ack   = pend_ack | spur_ack;
            wb_err   = pend_err;
            wb_rdata = pend_ack ? pend_data : '0;
            pend_ack = 1'b0;
            pend_err = 1'b0;
            if (wb_cyc && wb_stb) begin
                if (stall_cnt > 0) begin
                    wb_stall = 1'b1;
                    stall_cnt--;
                end else begin
                    wb_stall = 1'b0;
                    if (wb_we) begin
                        mem[wb_addr] = wb_wdata;
                        wr_acc++;
                        pend_ack = 1'b1;
                    end else begin
                        rd_acc++;
                        if (int'(wb_addr) == err_rd_addr) pend_err = 1'b1;
                        else begin
                            pend_ack  = 1'b1;
                            pend_data = (int'(wb_addr) == corrupt_addr) ? '0 : mem[wb_addr];
                        end
                    end
                end
            end else wb_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_slave();
        for (int i = 0; i < 256; i++) mem[i] = '0;
        wr_acc = 0; rd_acc = 0;
    endtask

    // n = cycles from the edge that accepts start until o_done is seen
    task automatic run(output int n);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!done && n < 1000) begin n++; tick(); end
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL run_bound: done=%b after %0d cycles, required 1", done, n); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        tick(); tick();
        vectors++;
        if ({wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata} !== '0) begin miscompares++; $display("FAIL reset_bus: got %h required 0", {wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata}); end
        vectors++;
        if ({busy, done, pass, fault, err_count} !== '0) begin miscompares++; $display("FAIL reset_status: got %h required 0", {busy, done, pass, fault, err_count}); end
        vectors++;
        if (wb_sel !== 1'b1) begin miscompares++; $display("FAIL reset_sel: got %b required 1", wb_sel); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ideal();
        int n;
        clear_slave();
        run(n);
        vectors++;
        if (n !== 23) begin miscompares++; $display("FAIL ideal_latency: got %0d required 23", n); end
        vectors++;
        if ({busy, done, pass, fault, err_count} !== {4'b0110, 9'd0}) begin miscompares++; $display("FAIL ideal_status: got %h required %h", {busy, done, pass, fault, err_count}, {4'b0110, 9'd0}); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (mem[i] !== exp_pat[i]) begin miscompares++; $display("FAIL ideal_mem[%0d]: got %h required %h", i, mem[i], exp_pat[i]); end
        end
        vectors++;
        if (wr_acc !== 4 || rd_acc !== 4) begin miscompares++; $display("FAIL ideal_accepts: got %0d/%0d required 4/4", wr_acc, rd_acc); end
        vectors++;
        if (wb_cyc !== 1'b0) begin miscompares++; $display("FAIL ideal_cyc_idle: got %b required 0", wb_cyc); end
    endtask

    task automatic test_corrupt();
        int n;
        clear_slave();
        corrupt_addr = 2;
        run(n);
        corrupt_addr = -1;
        vectors++;
        if (n !== 23) begin miscompares++; $display("FAIL corrupt_latency: got %0d required 23", n); end
        vectors++;
        if ({done, pass, fault} !== 3'b100) begin miscompares++; $display("FAIL corrupt_status: got %b required 100", {done, pass, fault}); end
        vectors++;
        if (err_count !== 9'd1) begin miscompares++; $display("FAIL corrupt_count: got %0d required 1", err_count); end
    endtask

    task automatic test_stall();
        int n;
        clear_slave();
        stall_cnt = 5;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata} !== {3'b111, 8'h00, 8'hA5}) begin miscompares++; $display("FAIL stall_hold[%0d]: got %h required %h", i, {wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata}, {3'b111, 8'h00, 8'hA5}); end
            tick();
        end
        n = 5;
        while (!done && n < 1000) begin n++; tick(); end
        vectors++;
        if (n !== 28) begin miscompares++; $display("FAIL stall_latency: got %0d required 28", n); end
        vectors++;
        if ({done, pass, fault} !== 3'b110) begin miscompares++; $display("FAIL stall_status: got %b required 110", {done, pass, fault}); end
        vectors++;
        if (wr_acc !== 4) begin miscompares++; $display("FAIL stall_single_accept: got %0d writes required 4", wr_acc); end

        clear_slave();
        stall_cnt = 300;
        run(n);
        stall_cnt = 0;
        vectors++;
        if (n !== 255) begin miscompares++; $display("FAIL timeout_latency: got %0d required 255", n); end
        vectors++;
        if ({wb_cyc, busy, done, pass, fault} !== 5'b00101) begin miscompares++; $display("FAIL timeout_status: got %b required 00101", {wb_cyc, busy, done, pass, fault}); end
        vectors++;
        if (wr_acc !== 0) begin miscompares++; $display("FAIL timeout_accepts: got %0d required 0", wr_acc); end
    endtask

    task automatic test_err();
        int n;
        clear_slave();
        err_rd_addr = 1;
        run(n);
        err_rd_addr = -1;
        vectors++;
        if (n !== 17) begin miscompares++; $display("FAIL err_latency: got %0d required 17", n); end
        vectors++;
        if ({wb_cyc, done, pass, fault} !== 4'b0101) begin miscompares++; $display("FAIL err_status: got %b required 0101", {wb_cyc, done, pass, fault}); end
        vectors++;
        if (err_count !== 9'd0 || rd_acc !== 2) begin miscompares++; $display("FAIL err_counts: got err=%0d reads=%0d required 0/2", err_count, rd_acc); end
    endtask

    task automatic test_start_reset();
        int n;
        clear_slave();
        tick();
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!done && n < 1000) begin start = (n == 6); n++; tick(); end
        start = 1'b0;
        vectors++;
        if (n !== 23 || pass !== 1'b1) begin miscompares++; $display("FAIL midstart: got n=%0d pass=%b required 23/1", n, pass); end

        clear_slave();
        tick();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1; start = 1'b1;
        tick();
        vectors++;
        if ({wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, busy, done, pass, fault, err_count} !== '0) begin miscompares++; $display("FAIL midreset_outputs: got %h required 0", {wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, busy, done, pass, fault, err_count}); end
        rst = 1'b0; start = 1'b0;
        tick();
        vectors++;
        if ({busy, wb_cyc} !== 2'b00) begin miscompares++; $display("FAIL reset_start_ignored: got %b required 00", {busy, wb_cyc}); end
        clear_slave();
        run(n);
        vectors++;
        if (n !== 23 || {done, pass, fault} !== 3'b110) begin miscompares++; $display("FAIL post_reset_run: got n=%0d st=%b required 23/110", n, {done, pass, fault}); end
        vectors++;
        if (mem[3] !== 8'hA6) begin miscompares++; $display("FAIL post_reset_mem3: got %h required a6", mem[3]); end
    endtask

    task automatic test_spurious_ack();
        tick();
        spur_ack = 1'b1;
        repeat (4) tick();
        spur_ack = 1'b0;
        tick();
        vectors++;
        if ({busy, wb_cyc, done, pass, fault} !== 5'b00110) begin miscompares++; $display("FAIL spur_status: got %b required 00110", {busy, wb_cyc, done, pass, fault}); end
        vectors++;
        if (err_count !== 9'd0 || wb_addr !== 8'd3) begin miscompares++; $display("FAIL spur_counters: got err=%0d addr=%0d required 0/3", err_count, wb_addr); end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_corrupt();
        test_stall();
        test_err();
        test_start_reset();
        test_spurious_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
